// File: rtl/flash_read_arbiter_if.sv
// Bus bundle for flash_read_arbiter: two burst requester ports plus the
// shared flashmem valid/ready/addr/rdata port.
//   reqN_start/addr/len : burst request (addr/len sampled with start)
//   reqN_busy           : request pending or in progress
//   reqN_data/valid     : read byte stream to requester N
//   reqN_done           : one-cycle pulse after the last byte of a burst
//   fm_valid/fm_addr    : flash read request and current byte address
//   fm_ready/fm_rdata   : flash byte strobe and read data
// Modport slave is the arbiter side; master is the requester/flash side.
interface flash_read_arbiter_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 17
);
  logic              req0_start;
  logic [ADDR_W-1:0] req0_addr;
  logic [LEN_W-1:0]  req0_len;
  logic              req0_busy;
  logic [7:0]        req0_data;
  logic              req0_valid;
  logic              req0_done;

  logic              req1_start;
  logic [ADDR_W-1:0] req1_addr;
  logic [LEN_W-1:0]  req1_len;
  logic              req1_busy;
  logic [7:0]        req1_data;
  logic              req1_valid;
  logic              req1_done;

  logic              fm_valid;
  logic [ADDR_W-1:0] fm_addr;
  logic              fm_ready;
  logic [7:0]        fm_rdata;

  modport slave (
    input  req0_start, req0_addr, req0_len,
    output req0_busy, req0_data, req0_valid, req0_done,
    input  req1_start, req1_addr, req1_len,
    output req1_busy, req1_data, req1_valid, req1_done,
    output fm_valid, fm_addr,
    input  fm_ready, fm_rdata
  );

  modport master (
    output req0_start, req0_addr, req0_len,
    input  req0_busy, req0_data, req0_valid, req0_done,
    output req1_start, req1_addr, req1_len,
    input  req1_busy, req1_data, req1_valid, req1_done,
    input  fm_valid, fm_addr,
    output fm_ready, fm_rdata
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Shares one byte-serial SPI flash reader between two burst requesters.
// Requester 0 has fixed priority at burst boundaries; bursts are never
// pre-empted or interleaved. Each burst is followed by a one-cycle GAP with
// fm_valid low so the flash controller closes its SPI transaction.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset (aborts any burst, no done pulse)
//   bus   : flash_read_arbiter_if.slave (requester ports + flashmem port)
module flash_read_arbiter #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 17
) (
  input  logic                  clock,
  input  logic                  reset,
  flash_read_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        busy_q, busy_d;
  logic [1:0]        done_q, done_d;
  logic [ADDR_W-1:0] slot_addr_q [2];
  logic [ADDR_W-1:0] slot_addr_d [2];
  logic [LEN_W-1:0]  slot_len_q  [2];
  logic [LEN_W-1:0]  slot_len_d  [2];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              fm_valid_q, fm_valid_d;

  logic [1:0]        start_c;
  logic [ADDR_W-1:0] in_addr_c [2];
  logic [LEN_W-1:0]  in_len_c  [2];
  logic              pick_c;
  logic              xfer_c;

  // Gather requester inputs into indexable form.
  assign start_c      = {bus.req1_start, bus.req0_start};
  assign in_addr_c[0] = bus.req0_addr;
  assign in_addr_c[1] = bus.req1_addr;
  assign in_len_c[0]  = bus.req0_len;
  assign in_len_c[1]  = bus.req1_len;

  // Next-state: request capture, arbitration and burst sequencing.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    pend_d      = pend_q;
    done_d      = 2'b00;
    slot_addr_d = slot_addr_q;
    slot_len_d  = slot_len_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    fm_valid_d  = fm_valid_q;
    pick_c      = 1'b0;

    // A start is only accepted by an idle requester with a non-empty burst;
    // this also drops a start coinciding with its own done pulse.
    for (int n = 0; n < 2; n++) begin
      if (start_c[n] && (in_len_c[n] != '0) && !busy_q[n]) begin
        pend_d[n]      = 1'b1;
        slot_addr_d[n] = in_addr_c[n];
        slot_len_d[n]  = in_len_c[n];
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_q != 2'b00) begin
          pick_c         = !pend_q[0];
          grant_d        = pick_c;
          pend_d[pick_c] = 1'b0;
          addr_d         = slot_addr_q[pick_c];
          rem_d          = slot_len_q[pick_c];
          fm_valid_d     = 1'b1;
          state_d        = BURST;
        end
      end
      BURST: begin
        if (bus.fm_ready) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            // Last byte: fm_addr holds on the final address.
            fm_valid_d      = 1'b0;
            done_d[grant_q] = 1'b1;
            state_d         = GAP;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = pend_d;
    if (state_d != IDLE) begin
      busy_d[grant_d] = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      pend_q         <= 2'b00;
      busy_q         <= 2'b00;
      done_q         <= 2'b00;
      slot_addr_q[0] <= '0;
      slot_addr_q[1] <= '0;
      slot_len_q[0]  <= '0;
      slot_len_q[1]  <= '0;
      addr_q         <= '0;
      rem_q          <= '0;
      fm_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      pend_q         <= pend_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      slot_addr_q[0] <= slot_addr_d[0];
      slot_addr_q[1] <= slot_addr_d[1];
      slot_len_q[0]  <= slot_len_d[0];
      slot_len_q[1]  <= slot_len_d[1];
      addr_q         <= addr_d;
      rem_q          <= rem_d;
      fm_valid_q     <= fm_valid_d;
    end
  end

  // Byte strobe passes straight through to the granted requester only.
  assign xfer_c         = (state_q == BURST) && bus.fm_ready;
  assign bus.req0_valid = xfer_c && !grant_q;
  assign bus.req1_valid = xfer_c && grant_q;
  assign bus.req0_data  = bus.req0_valid ? bus.fm_rdata : 8'h00;
  assign bus.req1_data  = bus.req1_valid ? bus.fm_rdata : 8'h00;

  assign bus.req0_busy  = busy_q[0];
  assign bus.req1_busy  = busy_q[1];
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.fm_valid   = fm_valid_q;
  assign bus.fm_addr    = addr_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter: flash model strobes ready on every
// third fm_valid cycle and returns addr[7:0]^8'h5A; a negedge monitor logs
// every byte transfer and edge events for later comparison.
module tb_flash_read_arbiter;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned LEN_W  = 17;

  logic clock;
  logic reset;

  flash_read_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  flash_read_arbiter #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_err;
  int cyc;

  // Transfer log: address, requester code {req1_valid,req0_valid}, data, cycle.
  int xa[$];
  int xr[$];
  int xd[$];
  int xc[$];
  int rise_c[$];
  int fall_c[$];
  int b0f_c[$];
  int b1f_c[$];
  int d0_n, d1_n, d0_c, d1_c;
  logic pv, pb0, pb1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Flash model: ready on every third cycle of a continuous fm_valid run.
  int fm_cnt;
  always @(posedge clock) begin
    #1;
    if (!bus.fm_valid) begin
      fm_cnt       = 0;
      bus.fm_ready = 1'b0;
    end else begin
      bus.fm_ready = ((fm_cnt % 3) == 2);
      fm_cnt       = fm_cnt + 1;
    end
    bus.fm_rdata = bus.fm_addr[7:0] ^ 8'h5A;
  end

  // Monitor, sampled on the falling edge.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (bus.req0_valid || bus.req1_valid) begin
      xa.push_back(int'(bus.fm_addr));
      xr.push_back(int'({bus.req1_valid, bus.req0_valid}));
      xd.push_back(int'(bus.req0_valid ? bus.req0_data : bus.req1_data));
      xc.push_back(cyc);
    end
    if (bus.req0_done) begin d0_n = d0_n + 1; d0_c = cyc; end
    if (bus.req1_done) begin d1_n = d1_n + 1; d1_c = cyc; end
    if (bus.fm_valid && !pv) rise_c.push_back(cyc);
    if (!bus.fm_valid && pv) fall_c.push_back(cyc);
    if (!bus.req0_busy && pb0) b0f_c.push_back(cyc);
    if (!bus.req1_busy && pb1) b1f_c.push_back(cyc);
    pv  = bus.fm_valid;
    pb0 = bus.req0_busy;
    pb1 = bus.req1_busy;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_log();
    xa.delete(); xr.delete(); xd.delete(); xc.delete();
    rise_c.delete(); fall_c.delete(); b0f_c.delete(); b1f_c.delete();
    d0_n = 0; d1_n = 0; d0_c = -1; d1_c = -1;
  endtask

  task automatic drive(input int n, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    if (n == 0) begin
      bus.req0_start = 1'b1; bus.req0_addr = a; bus.req0_len = l;
    end else begin
      bus.req1_start = 1'b1; bus.req1_addr = a; bus.req1_len = l;
    end
  endtask

  task automatic release_starts();
    bus.req0_start = 1'b0;
    bus.req1_start = 1'b0;
  endtask

  task automatic start_req(input int n, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l,
                           output int sc);
    drive(n, a, l);
    sc = cyc;
    tick();
    release_starts();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((bus.req0_busy || bus.req1_busy || bus.fm_valid) && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_idle_timeout"}, 32'(k < budget), 32'd1);
    repeat (3) tick();
  endtask

  task automatic wait_xfers(input string tag, input int n);
    int k;
    k = 0;
    while (xa.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_xfer_timeout"}, 32'(k < 200), 32'd1);
  endtask

  task automatic chk_xfer(input string tag, input int i, input int a, input int code);
    int ea;
    ea = a & 32'hFF_FFFF;
    chk($sformatf("%s_addr%0d", tag, i), 32'(qget(xa, i)), 32'(ea));
    chk($sformatf("%s_req%0d", tag, i), 32'(qget(xr, i)), 32'(code));
    chk($sformatf("%s_data%0d", tag, i), 32'(qget(xd, i)), 32'((ea & 8'hFF) ^ 8'h5A));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sc;
    n_chk = 0; n_err = 0; cyc = 0;
    pv = 1'b0; pb0 = 1'b0; pb1 = 1'b0;
    clear_log();
    reset = 1'b1;
    bus.req0_start = 1'b0; bus.req0_addr = '0; bus.req0_len = '0;
    bus.req1_start = 1'b0; bus.req1_addr = '0; bus.req1_len = '0;
    repeat (3) tick();

    // Reset state.
    chk("rst_fm_valid", 32'(bus.fm_valid), 32'd0);
    chk("rst_fm_addr", 32'(bus.fm_addr), 32'd0);
    chk("rst_busy0", 32'(bus.req0_busy), 32'd0);
    chk("rst_busy1", 32'(bus.req1_busy), 32'd0);
    chk("rst_done0", 32'(bus.req0_done), 32'd0);
    chk("rst_valid0", 32'(bus.req0_valid), 32'd0);
    reset = 1'b0;
    repeat (2) tick();

    // Single burst with timing.
    clear_log();
    start_req(0, 24'h200000, 17'd4, sc);
    chk("t1_busy_next", 32'(bus.req0_busy), 32'd1);
    chk("t1_valid_early", 32'(bus.fm_valid), 32'd0);
    tick();
    chk("t1_fm_valid_lat2", 32'(bus.fm_valid), 32'd1);
    chk("t1_fm_addr0", 32'(bus.fm_addr), 32'h200000);
    wait_idle("t1", 200);
    chk("t1_nxfer", 32'(xa.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_xfer("t1", i, 32'h200000 + i, 1);
    chk("t1_rise", 32'(qget(rise_c, 0)), 32'(sc + 2));
    chk("t1_fall", 32'(qget(fall_c, 0)), 32'(qget(xc, 3) + 1));
    chk("t1_done_cyc", 32'(d0_c), 32'(qget(xc, 3) + 1));
    chk("t1_done_n", 32'(d0_n), 32'd1);
    chk("t1_busy_fall", 32'(qget(b0f_c, 0)), 32'(qget(xc, 3) + 2));
    chk("t1_fm_addr_hold", 32'(bus.fm_addr), 32'h200003);

    // Contention: both start together, requester 0 wins.
    clear_log();
    drive(0, 24'h200000, 17'd2);
    drive(1, 24'h010000, 17'd3);
    tick();
    release_starts();
    chk("t2_busy1", 32'(bus.req1_busy), 32'd1);
    wait_idle("t2", 300);
    chk("t2_nxfer", 32'(xa.size()), 32'd5);
    for (int i = 0; i < 2; i++) chk_xfer("t2", i, 32'h200000 + i, 1);
    for (int i = 0; i < 3; i++) chk_xfer("t2", 2 + i, 32'h010000 + i, 2);
    chk("t2_low_gap", 32'(qget(rise_c, 1) - qget(fall_c, 0)), 32'd2);
    chk("t2_b1_falls", 32'(b1f_c.size()), 32'd1);
    chk("t2_b1_fall_cyc", 32'(qget(b1f_c, 0)), 32'(qget(xc, 4) + 2));
    chk("t2_done0", 32'(d0_n), 32'd1);
    chk("t2_done1", 32'(d1_n), 32'd1);

    // No pre-emption of a running requester 1 burst.
    clear_log();
    start_req(1, 24'h030000, 17'd8, sc);
    wait_xfers("t3", 2);
    start_req(0, 24'h200010, 17'd2, sc);
    wait_idle("t3", 400);
    chk("t3_nxfer", 32'(xa.size()), 32'd10);
    for (int i = 0; i < 8; i++) chk_xfer("t3", i, 32'h030000 + i, 2);
    for (int i = 0; i < 2; i++) chk_xfer("t3", 8 + i, 32'h200010 + i, 1);
    chk("t3_bursts", 32'(rise_c.size()), 32'd2);
    chk("t3_fall", 32'(qget(fall_c, 0)), 32'(qget(xc, 7) + 1));

    // Ignored starts: zero length, and a start during an active burst.
    clear_log();
    drive(0, 24'h123456, 17'd0);
    tick();
    release_starts();
    chk("t4_len0_busy", 32'(bus.req0_busy), 32'd0);
    repeat (5) tick();
    chk("t4_len0_nxfer", 32'(xa.size()), 32'd0);
    chk("t4_len0_nvalid", 32'(rise_c.size()), 32'd0);
    chk("t4_len0_done", 32'(d0_n), 32'd0);
    start_req(0, 24'h100000, 17'd3, sc);
    wait_xfers("t4", 1);
    start_req(0, 24'h555555, 17'd7, sc);
    wait_idle("t4", 300);
    chk("t4_nxfer", 32'(xa.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk_xfer("t4", i, 32'h100000 + i, 1);
    chk("t4_done", 32'(d0_n), 32'd1);
    chk("t4_bursts", 32'(rise_c.size()), 32'd1);

    // Address wrap.
    clear_log();
    start_req(0, 24'hFFFFFE, 17'd4, sc);
    wait_idle("t5", 200);
    chk("t5_nxfer", 32'(xa.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk_xfer("t5", i, 32'hFFFFFE + i, 1);

    // Reset mid-burst, then a clean burst.
    clear_log();
    start_req(0, 24'h040000, 17'd5, sc);
    wait_xfers("t6", 2);
    reset = 1'b1;
    tick();
    chk("t6_fm_valid", 32'(bus.fm_valid), 32'd0);
    chk("t6_busy0", 32'(bus.req0_busy), 32'd0);
    chk("t6_done_now", 32'(bus.req0_done), 32'd0);
    reset = 1'b0;
    repeat (10) tick();
    chk("t6_no_done", 32'(d0_n), 32'd0);
    chk("t6_nxfer", 32'(xa.size()), 32'd2);
    chk("t6_idle_valid", 32'(bus.fm_valid), 32'd0);
    clear_log();
    start_req(0, 24'h050000, 17'd2, sc);
    wait_idle("t6b", 200);
    chk("t6b_nxfer", 32'(xa.size()), 32'd2);
    for (int i = 0; i < 2; i++) chk_xfer("t6b", i, 32'h050000 + i, 1);
    chk("t6b_done", 32'(d0_n), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single byte-serial SPI flash reader (the flashmem valid/ready/addr/rdata port) between two burst requesters.
- Requester 0 is the game loader streaming cartridge images. Requester 1 is a low-rate client, e.g. menu/OSD reading ROM titles and headers.
- Each request is a start address plus a byte count. The arbiter sequences the flash port one burst at a time, never interleaving.
- Requester 0 has fixed priority at burst boundaries; a burst in progress is never pre-empted.

Parameters:
- ADDR_W, 24, flash byte address width.
- LEN_W, 17, burst length width in bytes (max 2^LEN_W - 1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_start  in  1  one-cycle pulse requesting a burst
- req0_addr  in  ADDR_W  burst start address, sampled with req0_start
- req0_len  in  LEN_W  byte count, sampled with req0_start
- req0_busy  out  1  request pending or in progress
- req0_data  out  8  read byte (fm_rdata passthrough)
- req0_valid  out  1  req0_data valid this cycle
- req0_done  out  1  one-cycle pulse after the last byte of the burst
- req1_start, req1_addr, req1_len, req1_busy, req1_data, req1_valid, req1_done: identical semantics for requester 1
- fm_valid  out  1  flash read request
- fm_addr  out  ADDR_W  current flash byte address
- fm_ready  in  1  flashmem byte strobe; fm_rdata valid this cycle
- fm_rdata  in  8  flashmem read data

Behaviour:
- Reset: all outputs 0, state IDLE, both pending flags clear, len/addr registers cleared. Reset mid-burst aborts immediately; no done pulse is issued for the aborted burst.

Request capture:
- reqN_start with reqN_len != 0 and reqN_busy == 0 latches addr/len into requester N's slot and sets pendN. reqN_busy = 1 from the next cycle.
- reqN_start while reqN_busy == 1 is ignored.
- reqN_start with reqN_len == 0 is ignored; busy stays 0 and no done pulse is issued.

FSM states: IDLE, BURST, GAP.
- IDLE: if pend0, grant 0; else if pend1, grant 1. On grant:
  - load cur_addr/remaining from the slot and clear the pend flag;
  - next state BURST, fm_valid = 1 from the next cycle.
  - Start-to-fm_valid latency is 2 cycles when idle.
- BURST: fm_valid = 1 and fm_addr = cur_addr. On each fm_ready:
  - cur_addr += 1, wrapping modulo 2^ADDR_W;
  - remaining -= 1;
  - reqG_valid = fm_ready (combinational) and reqG_data = fm_rdata, where G is the granted requester.
  - On the fm_ready where remaining == 1: fm_valid <= 0, go to GAP.
- GAP: exactly one cycle with fm_valid = 0, forcing flashmem to end its SPI transaction. In this cycle:
  - reqG_done = 1;
  - reqG_busy clears at the end of the cycle;
  - next state IDLE.
- Back-to-back bursts: minimum 2 cycles with fm_valid low between bursts (GAP plus IDLE).
- Priority: evaluated only in IDLE. If both are pending, 0 wins and 1 stays pending. Requester 1 can starve while requester 0 keeps re-requesting; this is accepted.

Other rules:
- fm_ready is ignored outside BURST, and reqN_valid = 0 for the non-granted requester at all times.
- fm_addr holds its last value when fm_valid = 0.
- Simultaneous reqN_start and reqN_done in the same cycle: the start is ignored because busy is still 1.
- reqN_busy = pendN | (granted N and state != IDLE).

Test Plan:
- Single burst: req0_start, addr = 0x200000, len = 4; flash model asserts ready every 3rd cycle.
  - Expect fm_addr 0x200000..0x200003 and four req0_valid pulses carrying the model bytes.
  - Expect fm_valid to drop on the cycle after the 4th ready, req0_done in GAP, and req0_busy to fall after GAP.
- Contention: req0 and req1 start in the same cycle (req0 addr 0x200000 len 2, req1 addr 0x010000 len 3).
  - Expect the req0 burst first, then at least 2 cycles of fm_valid = 0, then the req1 burst at 0x010000.
  - Expect req1_busy high throughout.
- No pre-emption: req1 is in a len = 8 burst and req0_start arrives after byte 2.
  - Expect all 8 req1 bytes delivered contiguously, then the req0 burst.
- Ignored starts: req0_start with len = 0 -> busy stays 0, no flash activity.
  - A second req0_start during an active burst is ignored; the address/len of the running burst are unchanged.
- Wrap: addr = 0xFFFFFE, len = 4 -> fm_addr sequence FFFFFE, FFFFFF, 000000, 000001.
- Reset mid-burst: assert reset after 2 of 5 bytes.
  - Next cycle: fm_valid = 0, busy = 0, no done pulse.
  - A new req0_start after reset completes normally.
